// File: rtl/csr_unit.sv
// Machine-mode CSR file: zero-latency reads, writes/traps/MRET commit on the clock edge, no backpressure.
// Optional mcycle/minstret counters are built when CSR_COUNTERS_EN is defined.
module csr_unit #(
  parameter logic [63:0] MTVEC_RESET = 64'h0000_0000_0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] r_csr_addr,
  output logic [63:0] csr_data,
  input  logic        we_csr,
  input  logic [63:0] w_csr_data,
  input  logic        exc_en,
  input  logic [3:0]  exc_code,
  input  logic [63:0] exc_val,
  input  logic        mret,
  input  logic [63:0] pc_addr,
  input  logic        instr_retire,
  output logic [1:0]  priv_lvl,
  output logic        redirect,
  output logic [63:0] redirect_pc
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MISA     = 12'h301;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MTVAL    = 12'h343;
  localparam logic [11:0] ADDR_MHARTID  = 12'hF14;
  localparam logic [63:0] MISA_VALUE    = 64'h8000_0000_0000_0100;
  localparam logic [1:0]  PRIV_M        = 2'd3;

  logic        mie_q, mie_d;
  logic        mpie_q, mpie_d;
  logic [1:0]  mpp_q, mpp_d;
  logic [1:0]  priv_q, priv_d;
  logic [63:0] mtvec_q, mtvec_d;
  logic [63:0] mscratch_q, mscratch_d;
  logic [63:0] mepc_q, mepc_d;
  logic [63:0] mcause_q, mcause_d;
  logic [63:0] mtval_q, mtval_d;
  logic [63:0] mstatus_rd;

  logic        mret_ok;
  logic        wr_ok;

  assign mret_ok    = mret && !exc_en && (priv_q == PRIV_M);
  // Any mret (even an illegal one) suppresses a same-cycle CSR write.
  assign wr_ok      = we_csr && !exc_en && !mret;
  assign mstatus_rd = {51'b0, mpp_q, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
  assign priv_lvl   = priv_q;

`ifdef CSR_COUNTERS_EN
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET = 12'hB02;

  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;
  logic        unused_ok;

  assign unused_ok = ^pc_addr[1:0];

  always_comb begin
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + {63'b0, instr_retire};
    if (wr_ok && r_csr_addr == ADDR_MCYCLE)   mcycle_d   = w_csr_data;
    if (wr_ok && r_csr_addr == ADDR_MINSTRET) minstret_d = w_csr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcycle_q   <= 64'd0;
      minstret_q <= 64'd0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end
`else
  logic unused_ok;

  assign unused_ok = ^{pc_addr[1:0], instr_retire};
`endif

  always_comb begin
    csr_data = 64'd0;
    case (r_csr_addr)
      ADDR_MSTATUS:  csr_data = mstatus_rd;
      ADDR_MISA:     csr_data = MISA_VALUE;
      ADDR_MTVEC:    csr_data = mtvec_q;
      ADDR_MSCRATCH: csr_data = mscratch_q;
      ADDR_MEPC:     csr_data = mepc_q;
      ADDR_MCAUSE:   csr_data = mcause_q;
      ADDR_MTVAL:    csr_data = mtval_q;
      ADDR_MHARTID:  csr_data = 64'd0;
`ifdef CSR_COUNTERS_EN
      ADDR_MCYCLE:   csr_data = mcycle_q;
      ADDR_MINSTRET: csr_data = minstret_q;
`endif
      default:       csr_data = 64'd0;
    endcase
  end

  always_comb begin
    mie_d       = mie_q;
    mpie_d      = mpie_q;
    mpp_d       = mpp_q;
    priv_d      = priv_q;
    mtvec_d     = mtvec_q;
    mscratch_d  = mscratch_q;
    mepc_d      = mepc_q;
    mcause_d    = mcause_q;
    mtval_d     = mtval_q;
    redirect    = 1'b0;
    redirect_pc = 64'd0;

    if (exc_en) begin
      redirect    = 1'b1;
      redirect_pc = mtvec_q;
      mepc_d      = {pc_addr[63:2], 2'b00};
      mcause_d    = {60'b0, exc_code};
      mtval_d     = exc_val;
      mpie_d      = mie_q;
      mie_d       = 1'b0;
      mpp_d       = priv_q;
      priv_d      = PRIV_M;
    end else if (mret_ok) begin
      redirect    = 1'b1;
      redirect_pc = mepc_q;
      priv_d      = mpp_q;
      mie_d       = mpie_q;
      mpie_d      = 1'b1;
      mpp_d       = 2'b00;
    end else if (wr_ok) begin
      case (r_csr_addr)
        ADDR_MSTATUS: begin
          mie_d  = w_csr_data[3];
          mpie_d = w_csr_data[7];
          // 2'b10 is a reserved privilege encoding; fold it to U.
          mpp_d  = (w_csr_data[12:11] == 2'b10) ? 2'b00 : w_csr_data[12:11];
        end
        ADDR_MTVEC:    mtvec_d    = {w_csr_data[63:2], 2'b00};
        ADDR_MSCRATCH: mscratch_d = w_csr_data;
        ADDR_MEPC:     mepc_d     = {w_csr_data[63:2], 2'b00};
        ADDR_MCAUSE:   mcause_d   = w_csr_data;
        ADDR_MTVAL:    mtval_d    = w_csr_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mpp_q      <= 2'b00;
      priv_q     <= PRIV_M;
      mtvec_q    <= {MTVEC_RESET[63:2], 2'b00};
      mscratch_q <= 64'd0;
      mepc_q     <= 64'd0;
      mcause_q   <= 64'd0;
      mtval_q    <= 64'd0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mpp_q      <= mpp_d;
      priv_q     <= priv_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
    end
  end

endmodule

// File: tb/tb_csr_unit.sv
// Bench for csr_unit: directed vector table, corner sequences, then random traffic against a reference model.
module tb_csr_unit;
  localparam logic [63:0] MTVEC_RST = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] r_csr_addr;
  logic [63:0] csr_data;
  logic        we_csr;
  logic [63:0] w_csr_data;
  logic        exc_en;
  logic [3:0]  exc_code;
  logic [63:0] exc_val;
  logic        mret;
  logic [63:0] pc_addr;
  logic        instr_retire;
  logic [1:0]  priv_lvl;
  logic        redirect;
  logic [63:0] redirect_pc;

  int total = 0;
  int bad   = 0;

  csr_unit #(.MTVEC_RESET(MTVEC_RST)) dut (
    .clk(clk), .rst_n(rst_n), .r_csr_addr(r_csr_addr), .csr_data(csr_data),
    .we_csr(we_csr), .w_csr_data(w_csr_data), .exc_en(exc_en), .exc_code(exc_code),
    .exc_val(exc_val), .mret(mret), .pc_addr(pc_addr), .instr_retire(instr_retire),
    .priv_lvl(priv_lvl), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [11:0] addr, input logic [63:0] wd,
                       input logic exc, input logic [3:0] code, input logic [63:0] pc,
                       input logic [63:0] val, input logic mr);
    we_csr = we; r_csr_addr = addr; w_csr_data = wd; exc_en = exc; exc_code = code;
    pc_addr = pc; exc_val = val; mret = mr; instr_retire = 1'b0;
  endtask

  // ---------------- reference model ----------------
  logic [63:0] m_mstatus, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_mcycle, m_minstret;
  logic [1:0]  m_priv;

  task automatic model_reset();
    m_mstatus = 0; m_mtvec = MTVEC_RST; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
    m_mtval = 0; m_mcycle = 0; m_minstret = 0; m_priv = 2'd3;
  endtask

  function automatic logic [63:0] model_read(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h301: return 64'h8000_0000_0000_0100;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
`ifdef CSR_COUNTERS_EN
      12'hB00: return m_mcycle;
      12'hB02: return m_minstret;
`endif
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic model_mret_ok();
    return mret && !exc_en && m_priv == 2'd3;
  endfunction

  // Apply the current input set to the model as one clock edge.
  task automatic model_step();
    logic [63:0] st;
    logic        cyc_written, ret_written;
    cyc_written = 0; ret_written = 0;
    st = m_mstatus;
    if (exc_en) begin
      m_mepc   = pc_addr & ~64'd3;
      m_mcause = {60'd0, exc_code};
      m_mtval  = exc_val;
      st[7]     = st[3];
      st[3]     = 1'b0;
      st[12:11] = m_priv;
      m_priv    = 2'd3;
    end else if (mret) begin
      if (m_priv == 2'd3) begin
        m_priv    = st[12:11];
        st[3]     = st[7];
        st[7]     = 1'b1;
        st[12:11] = 2'd0;
      end
    end else if (we_csr) begin
      case (r_csr_addr)
        12'h300: begin
          st = w_csr_data & 64'h1888;
          if (st[12:11] == 2'b10) st[12:11] = 2'b00;
        end
        12'h305: m_mtvec    = w_csr_data & ~64'd3;
        12'h340: m_mscratch = w_csr_data;
        12'h341: m_mepc     = w_csr_data & ~64'd3;
        12'h342: m_mcause   = w_csr_data;
        12'h343: m_mtval    = w_csr_data;
        12'hB00: begin m_mcycle = w_csr_data; cyc_written = 1; end
        12'hB02: begin m_minstret = w_csr_data; ret_written = 1; end
        default: ;
      endcase
    end
    m_mstatus = st;
    if (!cyc_written) m_mcycle = m_mcycle + 64'd1;
    if (!ret_written && instr_retire) m_minstret = m_minstret + 64'd1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [63:0] wdata;
    logic        exc;
    logic [3:0]  code;
    logic [63:0] pc;
    logic [63:0] val;
    logic        mr;
    logic [63:0] exp_data;
    logic        exp_redir;
    logic [63:0] exp_rpc;
    logic [1:0]  exp_priv;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic we, input logic [11:0] addr, input logic [63:0] wd,
                   input logic exc, input logic [3:0] code, input logic [63:0] pc,
                   input logic [63:0] val, input logic mr, input logic [63:0] ed,
                   input logic er, input logic [63:0] erpc, input logic [1:0] ep);
    vec_t t;
    t.we = we; t.addr = addr; t.wdata = wd; t.exc = exc; t.code = code; t.pc = pc;
    t.val = val; t.mr = mr; t.exp_data = ed; t.exp_redir = er; t.exp_rpc = erpc; t.exp_priv = ep;
    vecs.push_back(t);
  endtask

  initial begin
    // reset state / read-only registers
    v(0, 12'h305, 0, 0, 0, 0, 0, 0, 64'h8000_0000, 0, 0, 3);
    v(0, 12'h301, 0, 0, 0, 0, 0, 0, 64'h8000_0000_0000_0100, 0, 0, 3);
    v(0, 12'hF14, 0, 0, 0, 0, 0, 0, 64'h0, 0, 0, 3);
    // mscratch write, same-cycle read shows old value
    v(1, 12'h340, 64'hDEAD_BEEF, 0, 0, 0, 0, 0, 64'h0, 0, 0, 3);
    v(0, 12'h340, 0, 0, 0, 0, 0, 0, 64'hDEAD_BEEF, 0, 0, 3);
    // mstatus field masking and MPP=2'b10 folding
    v(1, 12'h300, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0, 0, 64'h0, 0, 0, 3);
    v(0, 12'h300, 0, 0, 0, 0, 0, 0, 64'h1888, 0, 0, 3);
    v(1, 12'h300, 64'h1008, 0, 0, 0, 0, 0, 64'h1888, 0, 0, 3);
    v(0, 12'h300, 0, 0, 0, 0, 0, 0, 64'h0008, 0, 0, 3);
    v(1, 12'h305, 64'h2003, 0, 0, 0, 0, 0, 64'h8000_0000, 0, 0, 3);
    // trap with MIE=1
    v(0, 12'h305, 0, 1, 4'd11, 64'h1002, 0, 0, 64'h2000, 1, 64'h2000, 3);
    v(0, 12'h341, 0, 0, 0, 0, 0, 0, 64'h1000, 0, 0, 3);
    v(0, 12'h342, 0, 0, 0, 0, 0, 0, 64'd11, 0, 0, 3);
    v(0, 12'h300, 0, 0, 0, 0, 0, 0, 64'h1880, 0, 0, 3);
    // mret back to M
    v(0, 12'h300, 0, 0, 0, 0, 0, 1, 64'h1880, 1, 64'h1000, 3);
    v(0, 12'h300, 0, 0, 0, 0, 0, 0, 64'h0088, 0, 0, 3);
    // trap beats a same-cycle mepc write
    v(1, 12'h341, 64'h5555, 1, 4'd2, 64'h3007, 64'hABC, 0, 64'h1000, 1, 64'h2000, 3);
    v(0, 12'h341, 0, 0, 0, 0, 0, 0, 64'h3004, 0, 0, 3);
    v(0, 12'h343, 0, 0, 0, 0, 0, 0, 64'hABC, 0, 0, 3);
    // MPP=S, then mret (drops same-cycle mscratch write) drops to S
    v(1, 12'h300, 64'h0800, 0, 0, 0, 0, 0, 64'h1880, 0, 0, 3);
    v(1, 12'h340, 64'h1234, 0, 0, 0, 0, 1, 64'hDEAD_BEEF, 1, 64'h3004, 3);
    v(0, 12'h340, 0, 0, 0, 0, 0, 0, 64'hDEAD_BEEF, 0, 0, 1);
    // mret outside M is ignored
    v(0, 12'h300, 0, 0, 0, 0, 0, 1, 64'h0080, 0, 0, 1);
    v(0, 12'h300, 0, 0, 0, 0, 0, 0, 64'h0080, 0, 0, 1);
    v(0, 12'h123, 0, 0, 0, 0, 0, 0, 64'h0, 0, 0, 1);

    drive(1, 12'h305, 64'h1111, 1, 4'd5, 64'h40, 0, 1);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exc, vecs[i].code,
            vecs[i].pc, vecs[i].val, vecs[i].mr);
      #1;
      check($sformatf("vec%0d csr_data", i), csr_data, vecs[i].exp_data);
      check($sformatf("vec%0d redirect", i), {63'd0, redirect}, {63'd0, vecs[i].exp_redir});
      check($sformatf("vec%0d redirect_pc", i), redirect_pc, vecs[i].exp_rpc);
      check($sformatf("vec%0d priv", i), {62'd0, priv_lvl}, {62'd0, vecs[i].exp_priv});
      @(posedge clk); #1;
    end

    // counter wrap / counter write handling
    drive(1, 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    drive(0, 12'hB00, 0, 0, 0, 0, 0, 0);
    #1;
`ifdef CSR_COUNTERS_EN
    check("mcycle written", csr_data, 64'hFFFF_FFFF_FFFF_FFFF);
    @(posedge clk); #2;
    check("mcycle wrap", csr_data, 64'h0);
`else
    check("mcycle absent", csr_data, 64'h0);
    @(posedge clk); #1;
    r_csr_addr = 12'hB02; #1;
    check("minstret absent", csr_data, 64'h0);
`endif

    // reset overrides concurrent trap / mret / write
    @(posedge clk); #1;
    drive(1, 12'h305, 64'h7777, 1, 4'd3, 64'h80, 64'h9, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    drive(0, 12'h305, 0, 0, 0, 0, 0, 0);
    #1;
    check("rst mtvec", csr_data, MTVEC_RST);
    check("rst priv", {62'd0, priv_lvl}, 64'd3);
    check("rst redirect", {63'd0, redirect}, 64'd0);
    @(posedge clk); #1; model_step();
    r_csr_addr = 12'h300; #1;
    check("rst mstatus", csr_data, 64'h0);
    @(posedge clk); #1; model_step();
    r_csr_addr = 12'h342; #1;
    check("rst mcause", csr_data, 64'h0);
    @(posedge clk); #1; model_step();

    // randomized traffic against the reference model
    begin
      logic [11:0] addrs [12];
      addrs = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342,
                12'h343, 12'hF14, 12'hB00, 12'hB02, 12'h123, 12'h7C0};
      for (int n = 0; n < 600; n++) begin
        r_csr_addr   = addrs[$urandom_range(0, 11)];
        we_csr       = ($urandom_range(0, 9) < 4);
        w_csr_data   = {$urandom, $urandom};
        exc_en       = ($urandom_range(0, 9) == 0);
        exc_code     = 4'($urandom);
        exc_val      = {$urandom, $urandom};
        mret         = ($urandom_range(0, 6) == 0);
        pc_addr      = {$urandom, $urandom};
        instr_retire = $urandom_range(0, 1) == 1;
        #1;
        check($sformatf("rnd%0d csr_data@%h", n, r_csr_addr), csr_data, model_read(r_csr_addr));
        check($sformatf("rnd%0d redirect", n), {63'd0, redirect},
              {63'd0, exc_en || model_mret_ok()});
        check($sformatf("rnd%0d redirect_pc", n), redirect_pc,
              exc_en ? m_mtvec : (model_mret_ok() ? m_mepc : 64'd0));
        check($sformatf("rnd%0d priv", n), {62'd0, priv_lvl}, {62'd0, m_priv});
        @(posedge clk); #1;
        model_step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
